// File: rtl/siphash_core_px_if.sv
// siphash_core_px_if
// Bundles the signals between the bus wrapper and the SipHash core.
//   master : wrapper side. Drives init/long/key, the round counts, the message
//            word handshake and finalize. Reads ready, the tag and tag valid.
//   slave  : core side. The same signals with the directions reversed.
// Parameter RND_W sets the width of the compression/final round-count fields.
interface siphash_core_px_if #(
    parameter int RND_W = 4
);
    logic             init;
    logic             long;
    logic [127:0]     key;
    logic [RND_W-1:0] compression_rounds;
    logic [RND_W-1:0] final_rounds;
    logic             mi_valid;
    logic [63:0]      mi;
    logic             mi_ready;
    logic             finalize;
    logic             ready;
    logic [127:0]     siphash_word;
    logic             siphash_word_valid;

    modport master (
        output init, long, key, compression_rounds, final_rounds,
               mi_valid, mi, finalize,
        input  mi_ready, ready, siphash_word, siphash_word_valid
    );

    modport slave (
        input  init, long, key, compression_rounds, final_rounds,
               mi_valid, mi, finalize,
        output mi_ready, ready, siphash_word, siphash_word_valid
    );
endinterface

// File: rtl/siphash_core_px.sv
// siphash_core_px
// SipHash-c-d core. It produces a 64-bit tag, or a 128-bit tag in long mode
// (SipHash-128). Each round cycle evaluates UNROLL SipRounds.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : init/long/key load the state. mi_valid/mi/mi_ready accept
//                  one message word with compression_rounds = c. finalize
//                  starts the tag computation with final_rounds = d. ready is
//                  high in IDLE. siphash_word = {word1, word0}, and
//                  siphash_word_valid flags a fresh tag.
// Parameters: UNROLL (1, 2 or 4) and RND_W (width of the round-count inputs).
module siphash_core_px #(
    parameter int UNROLL = 1,
    parameter int RND_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    siphash_core_px_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COMP  = 3'd1;
    localparam logic [2:0] ST_FIN   = 3'd2;
    localparam logic [2:0] ST_FIN_X = 3'd3;
    localparam logic [2:0] ST_FIN2  = 3'd4;

    typedef logic [RND_W:0] cnt_t;
    localparam cnt_t UNROLL_C = cnt_t'(UNROLL);

    logic [2:0]       state_q, state_d;
    logic [63:0]      v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             long_q, long_d;
    logic [63:0]      mi_q, mi_d;
    logic [RND_W-1:0] tgt_q, tgt_d;
    cnt_t             cnt_q, cnt_d;
    logic [63:0]      word0_q, word0_d, word1_q, word1_d;
    logic             valid_q, valid_d;

    cnt_t             remaining;
    cnt_t             rnds;
    logic             last_cycle;
    logic [255:0]     round_out;
    logic [63:0]      fold;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // One SipRound on a packed state {v3, v2, v1, v0}.
    function automatic logic [255:0] sip_round(input logic [255:0] s);
        logic [63:0] a, b, c, d;
        {d, c, b, a} = s;
        a = a + b; b = rotl(b, 13) ^ a; a = rotl(a, 32);
        c = c + d; d = rotl(d, 16) ^ c;
        a = a + d; d = rotl(d, 21) ^ a;
        c = c + b; b = rotl(b, 17) ^ c; c = rotl(c, 32);
        return {d, c, b, a};
    endfunction

    // Unrolled round chain. A stage is bypassed when fewer rounds than UNROLL
    // remain. A round count of zero therefore still costs one cycle, in which
    // the state passes through unchanged.
    always_comb begin
        remaining  = cnt_t'(tgt_q) - cnt_q;
        rnds       = (remaining < UNROLL_C) ? remaining : UNROLL_C;
        last_cycle = (remaining <= UNROLL_C);
        round_out  = {v3_q, v2_q, v1_q, v0_q};
        for (int i = 0; i < UNROLL; i++) begin
            if (cnt_t'(i) < rnds) begin
                round_out = sip_round(round_out);
            end
        end
        fold = round_out[63:0] ^ round_out[127:64] ^ round_out[191:128] ^ round_out[255:192];
    end

    // Next-state logic. init overrides everything, in any state.
    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        long_d  = long_q;
        mi_d    = mi_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        word0_d = word0_q;
        word1_d = word1_q;
        valid_d = valid_q;
        if (bus.init) begin
            v0_d    = bus.key[63:0]   ^ 64'h736f6d6570736575;
            v1_d    = bus.key[127:64] ^ 64'h646f72616e646f6d ^ {56'd0, bus.long ? 8'hee : 8'h00};
            v2_d    = bus.key[63:0]   ^ 64'h6c7967656e657261;
            v3_d    = bus.key[127:64] ^ 64'h7465646279746573;
            long_d  = bus.long;
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A word takes priority; a finalize pulse in the same cycle is dropped.
                    if (bus.mi_valid) begin
                        v3_d    = v3_q ^ bus.mi;
                        mi_d    = bus.mi;
                        tgt_d   = bus.compression_rounds;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = ST_COMP;
                    end else if (bus.finalize) begin
                        v2_d    = v2_q ^ {56'd0, long_q ? 8'hee : 8'hff};
                        tgt_d   = bus.final_rounds;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = ST_FIN;
                    end
                end
                ST_COMP: begin
                    {v3_d, v2_d, v1_d, v0_d} = round_out;
                    cnt_d = cnt_q + rnds;
                    if (last_cycle) begin
                        v0_d    = round_out[63:0] ^ mi_q;
                        state_d = ST_IDLE;
                    end
                end
                ST_FIN: begin
                    {v3_d, v2_d, v1_d, v0_d} = round_out;
                    cnt_d = cnt_q + rnds;
                    if (last_cycle) begin
                        word0_d = fold;
                        if (long_q) begin
                            state_d = ST_FIN_X;
                        end else begin
                            word1_d = '0;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FIN_X: begin
                    v1_d    = v1_q ^ 64'h00000000000000dd;
                    cnt_d   = '0;
                    state_d = ST_FIN2;
                end
                ST_FIN2: begin
                    {v3_d, v2_d, v1_d, v0_d} = round_out;
                    cnt_d = cnt_q + rnds;
                    if (last_cycle) begin
                        word1_d = fold;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
            long_q  <= 1'b0;
            mi_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            word0_q <= '0;
            word1_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            long_q  <= long_d;
            mi_q    <= mi_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready              = (state_q == ST_IDLE);
    assign bus.mi_ready           = (state_q == ST_IDLE);
    assign bus.siphash_word       = {word1_q, word0_q};
    assign bus.siphash_word_valid = valid_q;
endmodule
